// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit controller: func3 encodings,
// FSM states, default bus timeout and request legality helpers.
package lsu_pkg;

  localparam int TIMEOUT_DEFAULT = 255;

  // RISC-V load/store func3 encodings (size in [1:0], unsigned flag in [2])
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  // Stores only know signed sizes; loads additionally allow BU/HU
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Natural alignment check on the low address bits for the access size
  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return (a[0] == 1'b0);
      2'b10:   return (a == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables, store data replication and
// load data extraction with sign/zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] ldata
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  // Byte enables and replicated store data follow the access size
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    case (func3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
  end

  // Pick the addressed lane of the read word and extend it to 32 bits
  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rword[7:0];
      2'd1:    lane_b = rword[15:8];
      2'd2:    lane_b = rword[23:16];
      default: lane_b = rword[31:24];
    endcase
    lane_h = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (func3)
      F3_B:    ldata = 32'(lane_b);
      F3_H:    ldata = 32'(lane_h);
      F3_BU:   ldata = {24'b0, lane_b};
      F3_HU:   ldata = {16'b0, lane_h};
      default: ldata = rword;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one core memory request at a time,
// runs a single request/grant(/rvalid) bus transaction, stalls the core
// meanwhile and returns a one-cycle done pulse with error and load data.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // Counter is at least 8 bits but grows if TIMEOUT needs more
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  lsu_state_e       state, state_nxt;
  logic             we_q;
  logic [2:0]       func3_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic             req_ok;
  logic             accept;
  logic             tmo_hit;
  logic             tmo_abort;
  logic             load_done;
  logic [3:0]       be_w;
  logic [31:0]      wdata_w;
  logic [31:0]      ldata_w;

  assign req_ok  = f3_legal(req_we, req_func3) && addr_aligned(req_func3, req_addr[1:0]);
  assign accept  = (state == S_IDLE) && req_valid && req_ok;

  // tmo_hit marks the last bus cycle allowed; a grant/rvalid in that same
  // cycle still completes normally rather than aborting.
  assign tmo_hit   = (cnt == CNT_W'(TIMEOUT - 1));
  assign tmo_abort = tmo_hit && (((state == S_REQ) && !mem_gnt) ||
                                 ((state == S_WAIT) && !mem_rvalid));
  assign load_done = (state == S_WAIT) && mem_rvalid;

  assign mem_addr = {addr_q[31:2], 2'b00};

  lsu_align u_align (
    .func3     (func3_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rword     (mem_rdata),
    .be        (be_w),
    .wdata_rep (wdata_w),
    .ldata     (ldata_w)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and bus/core handshake outputs
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = wdata_w;
    stall     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          state_nxt = req_ok ? S_REQ : S_RESP;
        end
      end
      S_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = we_q;
        mem_be  = be_w;
        if (mem_gnt) begin
          state_nxt = we_q ? S_RESP : S_WAIT;
        end else if (tmo_hit) begin
          state_nxt = S_RESP;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (mem_rvalid || tmo_hit) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture the accepted request; these fields drive the bus through REQ
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      func3_q <= req_func3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Bus-cycle counter: cleared while idle, counts REQ and WAIT cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == S_IDLE) begin
      cnt <= '0;
    end else if ((state == S_REQ) || (state == S_WAIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Error flag presented with done: illegal/misaligned request or timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state == S_IDLE) && req_valid) begin
      err_q <= !req_ok;
    end else if (tmo_abort) begin
      err_q <= 1'b1;
    end
  end

  // Load result register: updated only by a completed load or a timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (load_done) begin
      rdata <= ldata_w;
    end else if (tmo_abort) begin
      rdata <= '0;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: each request pushes its expected outcome,
// which is popped and compared when the done pulse appears.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        gnt_en, rv_en, rv_force, rv_auto;
  logic [31:0] bus_rdata;

  lsu_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Simple bus: combinational grant, read data valid the cycle after a load grant
  assign mem_gnt    = mem_req & gnt_en;
  assign mem_rvalid = rv_auto | rv_force;
  assign mem_rdata  = bus_rdata;
  always @(posedge clk or posedge rst) begin
    if (rst) rv_auto <= 1'b0;
    else     rv_auto <= rv_en & mem_req & mem_gnt & ~mem_we;
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        bus;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] addr;
    logic        we;
    int          lat;
    int          reqc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_rdata = 32'h0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rword,
                                 input logic g, input logic r, input logic [31:0] prev);
    exp_t        e;
    logic        ok;
    logic [31:0] sh;
    ok = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (f3[1:0] == 2'd1 && addr[0]) ok = 1'b0;
    if (f3[1:0] == 2'd2 && addr[1:0] != 2'd0) ok = 1'b0;
    e.addr = {addr[31:2], 2'b00};
    e.we   = we;
    e.be   = 4'b0000;
    e.wd   = wdata;
    if (f3[1:0] == 2'd0) begin
      e.be[addr[1:0]] = 1'b1;
      e.wd = {wdata[7:0], wdata[7:0], wdata[7:0], wdata[7:0]};
    end else if (f3[1:0] == 2'd1) begin
      e.be[{addr[1], 1'b0} +: 2] = 2'b11;
      e.wd = {wdata[15:0], wdata[15:0]};
    end else begin
      e.be = 4'b1111;
    end
    sh = rword >> (8 * addr[1:0]);
    if (!ok) begin
      e.err = 1'b1; e.rdata = prev; e.bus = 1'b0; e.lat = 1; e.reqc = 0;
    end else if (!g) begin
      e.err = 1'b1; e.rdata = 32'h0; e.bus = 1'b0; e.lat = TMO + 1; e.reqc = TMO;
    end else if (we) begin
      e.err = 1'b0; e.rdata = prev; e.bus = 1'b1; e.lat = 2; e.reqc = 1;
    end else if (!r) begin
      e.err = 1'b1; e.rdata = 32'h0; e.bus = 1'b1; e.lat = TMO + 1; e.reqc = 1;
    end else begin
      e.err = 1'b0; e.bus = 1'b1; e.lat = 3; e.reqc = 1;
      case (f3)
        3'd0:    e.rdata = {{24{sh[7]}}, sh[7:0]};
        3'd1:    e.rdata = {{16{sh[15]}}, sh[15:0]};
        3'd4:    e.rdata = {24'h0, sh[7:0]};
        3'd5:    e.rdata = {16'h0, sh[15:0]};
        default: e.rdata = rword;
      endcase
    end
    return e;
  endfunction

  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rword,
                        input logic g, input logic r);
    exp_t        e, got;
    int          cyc, reqc;
    logic        seen_done, bus_seen, we_c;
    logic [3:0]  be_c;
    logic [31:0] wd_c, addr_c;
    e = model(we, f3, addr, wdata, rword, g, r, model_rdata);
    model_rdata = e.rdata;
    @(posedge clk); #1;
    gnt_en = g; rv_en = r; bus_rdata = rword;
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wdata;
    sb.push_back(e);
    cyc = 0; reqc = 0; seen_done = 1'b0; bus_seen = 1'b0;
    we_c = 1'b0; be_c = 4'h0; wd_c = 32'h0; addr_c = 32'h0;
    while (!seen_done && cyc < 60) begin
      @(negedge clk);
      if (cyc == 0 && !done) chk("stall_accept", {31'b0, stall}, 32'd1);
      if (mem_req) begin
        reqc++;
        if (mem_gnt) begin
          bus_seen = 1'b1; we_c = mem_we; be_c = mem_be; wd_c = mem_wdata; addr_c = mem_addr;
        end
      end
      if (done) begin
        seen_done = 1'b1;
        got = sb.pop_front();
        chk("err", {31'b0, err}, {31'b0, got.err});
        chk("rdata", rdata, got.rdata);
        chk("latency", cyc, got.lat);
        chk("stall_done", {31'b0, stall}, 32'd0);
        chk("req_cycles", reqc, got.reqc);
        chk("bus_granted", {31'b0, bus_seen}, {31'b0, got.bus});
        if (bus_seen) begin
          chk("mem_be", {28'b0, be_c}, {28'b0, got.be});
          chk("mem_addr", addr_c, got.addr);
          chk("mem_we", {31'b0, we_c}, {31'b0, got.we});
          if (got.we) chk("mem_wdata", wd_c, got.wd);
        end
      end else begin
        cyc++;
      end
    end
    if (!seen_done) begin
      chk("done_seen", 32'd0, 32'd1);
      if (sb.size() > 0) got = sb.pop_front();
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    gnt_en = 1'b1; rv_en = 1'b1; rv_force = 1'b0; bus_rdata = 32'h0;

    // Reset state
    #3;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall_lo", {31'b0, stall}, 32'd0);
    req_valid = 1'b1; #1;
    chk("rst_stall_hi", {31'b0, stall}, 32'd1);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1'b1, 1'b1);  // SB
    run_op(1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_8000, 1'b1, 1'b1);  // LB
    run_op(1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_8000, 1'b1, 1'b1);  // LBU
    run_op(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000, 1'b1, 1'b1);  // LH
    run_op(1'b0, 3'b010, 32'h0000_2002, 32'h0, 32'h1111_1111, 1'b1, 1'b1);  // LW misaligned
    run_op(1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234, 32'h0, 1'b1, 1'b1);  // SH
    run_op(1'b1, 3'b010, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b1);  // SW
    run_op(1'b0, 3'b101, 32'h0000_2000, 32'h0, 32'h0000_F00D, 1'b1, 1'b1);  // LHU
    run_op(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h1234_5678, 1'b1, 1'b1);  // LW
    run_op(1'b0, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 1'b1, 1'b1);          // illegal load
    run_op(1'b1, 3'b100, 32'h0000_3000, 32'h0, 32'h0, 1'b1, 1'b1);          // illegal store
    run_op(1'b1, 3'b001, 32'h0000_1001, 32'h5555, 32'h0, 1'b1, 1'b1);       // misaligned SH
    run_op(1'b0, 3'b000, 32'h0000_3003, 32'h0, 32'h7F00_0000, 1'b1, 1'b1);  // LB top lane
    run_op(1'b1, 3'b010, 32'h0000_4000, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b1);  // grant timeout
    run_op(1'b0, 3'b010, 32'h0000_4004, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1);  // LW
    run_op(1'b0, 3'b001, 32'h0000_4006, 32'h0, 32'h0, 1'b1, 1'b0);          // rvalid timeout

    // Random mix, including illegal and misaligned encodings
    for (int i = 0; i < 14; i++) begin
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom, 1'b1, 1'b1);
    end

    // Asynchronous reset while waiting for read data
    run_op(1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h0000_0042, 1'b1, 1'b1);
    @(posedge clk); #1;
    gnt_en = 1'b1; rv_en = 1'b0; bus_rdata = 32'hCAFE_BABE;
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h0000_6000;
    repeat (3) @(negedge clk);
    chk("wait_stall", {31'b0, stall}, 32'd1);
    chk("wait_no_req", {31'b0, mem_req}, 32'd0);
    #2;
    rst = 1'b1; req_valid = 1'b0;
    #1;
    chk("arst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("arst_stall", {31'b0, stall}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rv_force = 1'b1;
    @(negedge clk);
    rv_force = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_rvalid_done", {31'b0, done}, 32'd0);
      chk("late_rvalid_rdata", rdata, 32'd0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum bus cycles from first mem_req to completion before abort.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  core presents a load/store; held until done.
REQ-005 req_we  input  1  1=store, 0=load.
REQ-006 req_func3  input  3  instruction func3 (size/sign).
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-justified.
REQ-009 stall  output  1  freezes core PC/pipeline.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  valid with done; misaligned, illegal func3 or timeout.
REQ-012 rdata  output  32  extended load result.
REQ-013 mem_req, mem_we  output  1 each  bus request / write.
REQ-014 mem_addr  output  32  word address, {req_addr[31:2],2'b00}.
REQ-015 mem_be  output  4  byte enables.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_gnt, mem_rvalid  input  1 each  request accepted / read data valid.
REQ-018 mem_rdata  input  32  read word.

Function
REQ-019 FSM states IDLE, REQ, WAIT, RESP; reset state IDLE.
REQ-020 IDLE, req_valid=1, legal+aligned: latch we/func3/addr/wdata, clear timeout counter, go REQ.
REQ-021 IDLE, req_valid=1, illegal (load func3 011/110/111, store func3 >010) or misaligned (half addr[0]=1, word addr[1:0]!=0): no bus cycle, go RESP with err=1.
REQ-022 stall = (state in REQ,WAIT) or (state==IDLE and req_valid); stall=0 in RESP.
REQ-023 REQ: mem_req=1, address/be/wdata/we stable until mem_gnt; gnt with store -> RESP; gnt with load -> WAIT.
REQ-024 WAIT: on mem_rvalid capture extended data into rdata, go RESP; mem_rvalid in any other state ignored.
REQ-025 RESP: done=1 for exactly one cycle, then IDLE; new request sampled no earlier than next cycle.
REQ-026 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; same for loads.
REQ-027 Store data: byte replicated to all 4 lanes, half replicated to both halves, word unchanged.
REQ-028 Load extract: lane selected by addr[1:0] (byte) or addr[1] (half); func3 000/001 sign-extend, 100/101 zero-extend, 010 pass-through.
REQ-029 Timeout counter (8 bits min) increments each cycle in REQ/WAIT; reaching TIMEOUT -> RESP, err=1, rdata=0, mem_req dropped.
REQ-030 rdata holds last value until next load/timeout completion; stores and error responses except timeout leave it unchanged.
REQ-031 Minimum latency: store with immediate gnt completes (done) 2 cycles after acceptance; load with gnt then rvalid next cycle, 3 cycles.

Reset
REQ-032 rst asserted: state IDLE, mem_req=0, mem_we=0, mem_be=0, done=0, err=0, stall follows req_valid, rdata=0, counter=0, immediately, regardless of clk.
REQ-033 Reset mid-transaction aborts it; a late mem_rvalid/mem_gnt after reset is ignored.

Structure
REQ-034 Package lsu_pkg holds func3 constants, FSM state enum, default TIMEOUT.
REQ-035 One combinational sub-module lsu_align produces mem_be, mem_wdata and extended load data.

Verification
REQ-036 SB addr 0x1003 data 0xAB, gnt immediate -> mem_be=1000, mem_wdata=0xABABABAB, done 2 cycles later, err=0.
REQ-037 LB addr 0x2001, rdata word 0x0000_8000 -> rdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-038 LH addr 0x2002, rdata 0x8001_0000 -> rdata=0xFFFF_8001; LW addr 0x2002 -> err=1, done, mem_req never asserted.
REQ-039 TIMEOUT=4, gnt held low -> mem_req 4 cycles, then done, err=1, rdata=0, stall released.
REQ-040 rst asserted in WAIT -> mem_req/stall(req_valid=0) low asynchronously; rvalid after release ignored, rdata stays 0.
